multicycle_ctrl_fsm: RTL and testbench



---
 rtl/multicycle_ctrl_fsm_pkg.sv | 69 ++++++
 rtl/multicycle_ctrl_fsm_checker.sv | 15 +
 rtl/multicycle_ctrl_fsm_ctrl_output_decode.sv | 89 ++++++++
 rtl/multicycle_ctrl_fsm.sv | 112 +++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control unit: state encoding,
// opcode constants, operand/result select encodings and the control word.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_JAL    = 4'd9,
    S_BEQ    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Raw per-state control word; strobes are gated later by mem_ready/zero/reset.
  typedef struct packed {
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       adr_src;
    logic       ir_write;   // qualified by mem_ready
    logic       pc_update;  // qualified by mem_ready when mem_gated is set
    logic       mem_gated;
    logic       branch;     // qualified by zero
    logic       mem_write;  // qualified by mem_ready
    logic       reg_write;
  } ctrl_word_t;

  // An instruction completes when its last state hands control back to FETCH.
  function automatic logic instr_retires(input state_t s, input logic mem_ready);
    logic r;
    case (s)
      S_MEMWB, S_ALUWB, S_BEQ: r = 1'b1;
      S_MEMWR:                 r = mem_ready;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_checker.sv
// Protocol checks on the control outputs: the 2'b11 select code is reserved
// because the datapath muxes output zero for it.
module multicycle_ctrl_fsm_checker (
  input logic       clk,
  input logic       resetn,
  input logic [1:0] ALUSrcA,
  input logic [1:0] ALUSrcB,
  input logic [1:0] ResultSrc
);

  a_srca_legal: assert property (@(posedge clk) disable iff (!resetn) ALUSrcA != 2'b11);
  a_srcb_legal: assert property (@(posedge clk) disable iff (!resetn) ALUSrcB != 2'b11);
  a_res_legal:  assert property (@(posedge clk) disable iff (!resetn) ResultSrc != 2'b11);

endmodule

// File: rtl/multicycle_ctrl_fsm_ctrl_output_decode.sv
// Purely combinational state -> control word decoder (Moore outputs).
module ctrl_output_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  state_t     i_state,
  output ctrl_word_t o_cw
);

  ctrl_word_t w_cw;

  // Decode the raw control word for the current state; unlisted fields stay 0.
  always_comb begin
    w_cw = '0;
    case (i_state)
      S_FETCH: begin
        w_cw.alu_src_a  = SRCA_PC;
        w_cw.alu_src_b  = SRCB_FOUR;
        w_cw.alu_op     = ALUOP_ADD;
        w_cw.result_src = RES_ALU;
        w_cw.adr_src    = 1'b0;
        w_cw.ir_write   = 1'b1;
        w_cw.pc_update  = 1'b1;
        w_cw.mem_gated  = 1'b1;
      end
      S_DECODE: begin
        // Branch target (OldPC + imm) is precomputed into ALUOut here.
        w_cw.alu_src_a = SRCA_OLDPC;
        w_cw.alu_src_b = SRCB_IMM;
        w_cw.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        w_cw.alu_src_a = SRCA_RS1;
        w_cw.alu_src_b = SRCB_IMM;
        w_cw.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        w_cw.result_src = RES_ALUOUT;
        w_cw.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        w_cw.result_src = RES_MEM;
        w_cw.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        w_cw.result_src = RES_ALUOUT;
        w_cw.adr_src    = 1'b1;
        w_cw.mem_write  = 1'b1;
      end
      S_EXECR: begin
        w_cw.alu_src_a = SRCA_RS1;
        w_cw.alu_src_b = SRCB_RS2;
        w_cw.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        w_cw.alu_src_a = SRCA_RS1;
        w_cw.alu_src_b = SRCB_IMM;
        w_cw.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_cw.result_src = RES_ALUOUT;
        w_cw.reg_write  = 1'b1;
      end
      S_JAL: begin
        // OldPC + 4 is the link value; ALUOut holds the jump target from DECODE.
        w_cw.alu_src_a  = SRCA_OLDPC;
        w_cw.alu_src_b  = SRCB_FOUR;
        w_cw.alu_op     = ALUOP_ADD;
        w_cw.result_src = RES_ALUOUT;
        w_cw.pc_update  = 1'b1;
      end
      S_BEQ: begin
        w_cw.alu_src_a  = SRCA_RS1;
        w_cw.alu_src_b  = SRCB_RS2;
        w_cw.alu_op     = ALUOP_SUB;
        w_cw.result_src = RES_ALUOUT;
        w_cw.branch     = 1'b1;
      end
      S_TRAP: begin
        w_cw = '0;
      end
      default: begin
        w_cw = '0;
      end
    endcase
  end

  assign o_cw = w_cw;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control unit (lw, sw, R-type, I-type ALU, jal, beq):
// state sequencing, strobe gating, sticky illegal flag, retired counter.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int ILLEGAL_STICKY = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUOp,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  ctrl_word_t       w_cw;
  logic             w_retire;
  logic             w_pc_update;

  ctrl_output_decode u_decode (
    .i_state (r_state),
    .o_cw    (w_cw)
  );

  assign w_retire = instr_retires(r_state, mem_ready);

  // State sequencing, sticky illegal-opcode flag and retired-instruction count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
          else           r_state <= S_FETCH;
        end
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECR;
            OP_I:         r_state <= S_EXECI;
            OP_JAL:       r_state <= S_JAL;
            OP_BEQ:       r_state <= S_BEQ;
            default: begin
              r_illegal <= 1'b1;
              if (ILLEGAL_STICKY != 0) r_state <= S_TRAP;
              else                     r_state <= S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          if (opcode == OP_SW) r_state <= S_MEMWR;
          else                 r_state <= S_MEMRD;
        end
        S_MEMRD: begin
          if (mem_ready) r_state <= S_MEMWB;
          else           r_state <= S_MEMRD;
        end
        S_MEMWB: r_state <= S_FETCH;
        S_MEMWR: begin
          if (mem_ready) r_state <= S_FETCH;
          else           r_state <= S_MEMWR;
        end
        S_EXECR, S_EXECI: r_state <= S_ALUWB;
        S_ALUWB:          r_state <= S_FETCH;
        S_JAL:            r_state <= S_ALUWB;
        S_BEQ:            r_state <= S_FETCH;
        S_TRAP:           r_state <= S_TRAP;
        default:          r_state <= S_TRAP;
      endcase

      if (w_retire) r_retired <= r_retired + CNT_W'(1);
      else          r_retired <= r_retired;
    end
  end

  // FETCH's PC increment waits for the memory; JAL's jump does not.
  assign w_pc_update = w_cw.pc_update & (mem_ready | ~w_cw.mem_gated);

  assign ALUSrcA   = w_cw.alu_src_a;
  assign ALUSrcB   = w_cw.alu_src_b;
  assign ResultSrc = w_cw.result_src;
  assign ALUOp     = w_cw.alu_op;
  assign AdrSrc    = w_cw.adr_src;

  // Strobes are forced low while reset is held so nothing leaks after resetn falls.
  assign IRWrite  = resetn & w_cw.ir_write & mem_ready;
  assign PCWrite  = resetn & (w_pc_update | (w_cw.branch & zero));
  assign MemWrite = resetn & w_cw.mem_write & mem_ready;
  assign RegWrite = resetn & w_cw.reg_write;

  assign illegal  = r_illegal;
  assign retired  = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: instructions are expanded into
// the cycle-by-cycle phases the rules describe, and a compare process checks
// every cycle's outputs against a phase-name based model.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;

  typedef struct packed {
    logic [1:0] a, b, res, op;
    logic       adr, ir, pcw, mw, rw;
  } obs_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic        AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal;
  logic [31:0] retired;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          active = 1'b0;
  string       cur_ph = "FETCH";
  logic [31:0] exp_retired = 32'd0;
  bit          exp_illegal = 1'b0;
  int          ir_pulses = 0;

  multicycle_ctrl_fsm #(.CNT_W(32), .ILLEGAL_STICKY(1)) dut (
    .clk(clk), .resetn(resetn), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .illegal(illegal), .retired(retired)
  );

  multicycle_ctrl_fsm_checker u_chk (
    .clk(clk), .resetn(resetn), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc)
  );

  always #5 clk = ~clk;

  // What each phase must drive, straight from the per-state output rules.
  function automatic obs_t model(input string ph, input bit mr, input bit z);
    obs_t o;
    o = '0;
    if (ph == "FETCH") begin
      o.b = 2'b10; o.res = 2'b10; o.ir = mr; o.pcw = mr;
    end else if (ph == "DECODE") begin
      o.a = 2'b01; o.b = 2'b01;
    end else if (ph == "MEMADR") begin
      o.a = 2'b10; o.b = 2'b01;
    end else if (ph == "MEMRD") begin
      o.adr = 1'b1;
    end else if (ph == "MEMWB") begin
      o.res = 2'b01; o.rw = 1'b1;
    end else if (ph == "MEMWR") begin
      o.adr = 1'b1; o.mw = mr;
    end else if (ph == "EXECR") begin
      o.a = 2'b10; o.op = 2'b10;
    end else if (ph == "EXECI") begin
      o.a = 2'b10; o.b = 2'b01; o.op = 2'b10;
    end else if (ph == "ALUWB") begin
      o.rw = 1'b1;
    end else if (ph == "JAL") begin
      o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1;
    end else if (ph == "BEQ") begin
      o.a = 2'b10; o.op = 2'b01; o.pcw = z;
    end
    return o;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Per-cycle comparison of all outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (active) begin
      obs_t act, exp;
      act = {ALUSrcA, ALUSrcB, ResultSrc, ALUOp, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite};
      exp = model(cur_ph, mem_ready, zero);
      chk({"ctrl@", cur_ph}, longint'(act), longint'(exp));
      chk("retired", longint'(retired), longint'(exp_retired));
      chk("illegal", longint'(illegal), longint'(exp_illegal));
      if (IRWrite) ir_pulses++;
    end
  end

  // One clock in a named phase; called just after a rising edge.
  task automatic step(input string ph, input bit mr, input bit z, input bit completes);
    cur_ph    = ph;
    mem_ready = mr;
    zero      = z;
    active    = 1'b1;
    @(posedge clk); #1;
    if (completes) exp_retired = exp_retired + 32'd1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit z);
    opcode = op;
    for (int i = 0; i < fw; i++) step("FETCH", 1'b0, rb(), 1'b0);
    step("FETCH", 1'b1, rb(), 1'b0);
    step("DECODE", rb(), rb(), 1'b0);
    case (op)
      LW: begin
        step("MEMADR", rb(), rb(), 1'b0);
        for (int i = 0; i < mw; i++) step("MEMRD", 1'b0, rb(), 1'b0);
        step("MEMRD", 1'b1, rb(), 1'b0);
        step("MEMWB", rb(), rb(), 1'b1);
      end
      SW: begin
        step("MEMADR", rb(), rb(), 1'b0);
        for (int i = 0; i < mw; i++) step("MEMWR", 1'b0, rb(), 1'b0);
        step("MEMWR", 1'b1, rb(), 1'b1);
      end
      RT: begin
        step("EXECR", rb(), rb(), 1'b0);
        step("ALUWB", rb(), rb(), 1'b1);
      end
      IT: begin
        step("EXECI", rb(), rb(), 1'b0);
        step("ALUWB", rb(), rb(), 1'b1);
      end
      JAL: begin
        step("JAL", rb(), rb(), 1'b0);
        step("ALUWB", rb(), rb(), 1'b1);
      end
      BEQ: begin
        step("BEQ", rb(), z, 1'b1);
      end
      default: begin
        exp_illegal = 1'b1;
        cur_ph = "TRAP";
      end
    endcase
  endtask

  initial begin
    logic [6:0] ops [6];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = JAL; ops[5] = BEQ;

    // Reset with memory ready: strobes must stay low, selects show FETCH.
    resetn = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = RT;
    #3;
    chk("rst_IRWrite", longint'(IRWrite), 0);
    chk("rst_PCWrite", longint'(PCWrite), 0);
    chk("rst_ALUSrcB", longint'(ALUSrcB), 2);
    chk("rst_ResultSrc", longint'(ResultSrc), 2);
    chk("rst_retired", longint'(retired), 0);
    chk("rst_illegal", longint'(illegal), 0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    // Directed sequence from the test plan, with literal pins on the count.
    run_instr(RT, 0, 0, 1'b0);
    chk("retired_after_r", longint'(retired), 1);
    ir_pulses = 0;
    run_instr(LW, 3, 2, 1'b0);
    chk("lw_ir_pulses", longint'(ir_pulses), 1);
    chk("retired_after_lw", longint'(retired), 2);
    run_instr(BEQ, 0, 0, 1'b1);
    run_instr(BEQ, 0, 0, 1'b0);
    chk("retired_after_beq", longint'(retired), 4);
    run_instr(JAL, 0, 0, 1'b0);
    run_instr(SW, 1, 1, 1'b0);
    chk("retired_after_sw", longint'(retired), 6);

    // Randomized legal instruction stream.
    for (int n = 0; n < 150; n++) begin
      run_instr(ops[$urandom_range(0, 5)], int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), rb());
    end

    // Reset dropped inside MEMWR while memory is ready.
    opcode = SW;
    step("FETCH", 1'b1, 1'b0, 1'b0);
    step("DECODE", 1'b1, 1'b0, 1'b0);
    step("MEMADR", 1'b0, 1'b0, 1'b0);
    active = 1'b0; mem_ready = 1'b1;
    #1;
    chk("memwr_strobe_before_rst", longint'(MemWrite), 1);
    resetn = 1'b0;
    #1;
    chk("memwr_strobe_in_rst", longint'(MemWrite), 0);
    chk("pcwrite_in_rst", longint'(PCWrite), 0);
    chk("irwrite_in_rst", longint'(IRWrite), 0);
    chk("retired_in_rst", longint'(retired), 0);
    @(posedge clk); #1;
    resetn = 1'b1; exp_retired = 32'd0; exp_illegal = 1'b0;
    run_instr(IT, 0, 0, 1'b0);
    chk("retired_after_rst", longint'(retired), 1);

    // Unknown opcode parks in TRAP with the count frozen.
    run_instr(7'b1111111, 1, 0, 1'b0);
    for (int i = 0; i < 6; i++) step("TRAP", rb(), rb(), 1'b0);
    chk("trap_illegal", longint'(illegal), 1);
    chk("trap_retired", longint'(retired), 1);

    // Reset pulse leaves TRAP.
    active = 1'b0; mem_ready = 1'b1;
    resetn = 1'b0;
    #1;
    chk("trap_rst_illegal", longint'(illegal), 0);
    chk("trap_rst_retired", longint'(retired), 0);
    chk("trap_rst_ALUSrcB", longint'(ALUSrcB), 2);
    @(posedge clk); #1;
    resetn = 1'b1; exp_retired = 32'd0; exp_illegal = 1'b0;
    run_instr(RT, 2, 0, 1'b0);
    chk("retired_final", longint'(retired), 1);

    active = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
